// File: rtl/inst_dispatch_queue_pkg.sv
// Shared decode definitions for the instruction dispatch queue: op IDs, RV32I
// opcodes, instruction classes and the decoded-instruction record.
package inst_dispatch_queue_pkg;

  typedef enum logic [5:0] {
    OP_INV   = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
    OP_LHU   = 6'd15,
    OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } op_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    CLS_INV, CLS_U, CLS_J, CLS_I, CLS_B, CLS_LOAD, CLS_STORE, CLS_R
  } cls_e;

  typedef struct packed {
    op_e         op;
    cls_e        cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } dec_t;

  function automatic logic cls_to_lsb(input cls_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

  function automatic logic cls_to_rs(input cls_e cls);
    return (cls != CLS_INV) && !cls_to_lsb(cls);
  endfunction

  // Invalid entries still need a free RS slot so they cannot overtake a stall.
  function automatic logic unit_free(input cls_e cls, input logic rs_full,
                                     input logic lsb_full);
    return cls_to_lsb(cls) ? !lsb_full : !rs_full;
  endfunction

endpackage

// File: rtl/inst_dispatch_queue_decode.sv
// rv32i_decode: combinational RV32I decode of one word into op/class/regs/imm.
module rv32i_decode
  import inst_dispatch_queue_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  op_e         op;
  cls_e        cls;
  logic [31:0] imm;

  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  always_comb begin
    op  = OP_INV;
    cls = CLS_INV;
    imm = '0;
    case (inst[6:0])
      OPC_LUI:   begin op = OP_LUI;   cls = CLS_U; imm = imm_u; end
      OPC_AUIPC: begin op = OP_AUIPC; cls = CLS_U; imm = imm_u; end
      OPC_JAL:   begin op = OP_JAL;   cls = CLS_J; imm = imm_j; end
      OPC_JALR:
        if (f3 == 3'b000) begin op = OP_JALR; cls = CLS_I; imm = imm_i; end
      OPC_BRANCH: begin
        cls = CLS_B;
        imm = imm_b;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_INV;
        endcase
      end
      OPC_LOAD: begin
        cls = CLS_LOAD;
        imm = imm_i;
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_INV;
        endcase
      end
      OPC_STORE: begin
        cls = CLS_STORE;
        imm = imm_s;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_INV;
        endcase
      end
      OPC_OPIMM: begin
        cls = CLS_I;
        imm = imm_i;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: begin
            imm = imm_sh;
            if (f7 == 7'b0000000) op = OP_SLLI;
          end
          default: begin
            imm = imm_sh;
            if (f7 == 7'b0000000)      op = OP_SRLI;
            else if (f7 == 7'b0100000) op = OP_SRAI;
          end
        endcase
      end
      OPC_OP: begin
        cls = CLS_R;
        case ({f7, f3})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_110: op = OP_OR;
          10'b0000000_111: op = OP_AND;
          default:         op = OP_INV;
        endcase
      end
      default: op = OP_INV;
    endcase

    dec.op  = op;
    dec.cls = cls;
    dec.rd  = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.imm = imm;
    if (op == OP_INV) begin
      dec.cls = CLS_INV;
      dec.rd  = '0;
      dec.rs1 = '0;
      dec.rs2 = '0;
      dec.imm = '0;
    end else begin
      if (cls == CLS_B || cls == CLS_STORE) dec.rd = '0;
      if (cls == CLS_U || cls == CLS_J) dec.rs1 = '0;
      if (cls == CLS_U || cls == CLS_J || cls == CLS_I || cls == CLS_LOAD) dec.rs2 = '0;
    end
  end

endmodule

// File: rtl/inst_dispatch_queue.sv
// Instruction buffer + decode/dispatch stage between IF and ROB/RS/LSB.
// Optional DISPATCH_BYPASS_EN: an instruction arriving at an empty queue dispatches in one edge.
module inst_dispatch_queue
  import inst_dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_pred_taken,
  output logic             if_ready,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             disp_valid,
  output logic             disp_to_rs,
  output logic             disp_to_lsb,
  output logic [5:0]       disp_op,
  output logic [4:0]       disp_rd,
  output logic [4:0]       disp_rs1,
  output logic [4:0]       disp_rs2,
  output logic [31:0]      disp_imm,
  output logic [XLEN-1:0]  disp_pc,
  output logic             disp_pred_taken,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [31:0]      q_inst [DEPTH];
  logic [XLEN-1:0]  q_pc   [DEPTH];
  logic             q_pred [DEPTH];
  logic [PTR_W-1:0] head, tail;

  dec_t             head_dec, sel_dec;
  logic [XLEN-1:0]  sel_pc;
  logic             sel_pred;
  logic             push, pop, bypass, store, take;

  assign if_ready = (count != FULL);
  assign push     = if_valid && if_ready && rdy && !flush;
  assign pop      = (count != '0) && rdy && !flush && !rob_full &&
                    unit_free(head_dec.cls, rs_full, lsb_full);

  rv32i_decode u_head_dec (
    .inst (q_inst[head]),
    .dec  (head_dec)
  );

`ifdef DISPATCH_BYPASS_EN
  dec_t in_dec;

  rv32i_decode u_in_dec (
    .inst (if_inst),
    .dec  (in_dec)
  );

  // pop requires count != 0, so bypass and pop are mutually exclusive.
  assign bypass   = push && (count == '0) && !rob_full &&
                    unit_free(in_dec.cls, rs_full, lsb_full);
  assign sel_dec  = bypass ? in_dec        : head_dec;
  assign sel_pc   = bypass ? if_pc         : q_pc[head];
  assign sel_pred = bypass ? if_pred_taken : q_pred[head];
`else
  assign bypass   = 1'b0;
  assign sel_dec  = head_dec;
  assign sel_pc   = q_pc[head];
  assign sel_pred = q_pred[head];
`endif

  assign store = push && !bypass;
  assign take  = pop || bypass;

  always_ff @(posedge clk) begin
    if (store) begin
      q_inst[tail] <= if_inst;
      q_pc[tail]   <= if_pc;
      q_pred[tail] <= if_pred_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      disp_valid      <= 1'b0;
      disp_to_rs      <= 1'b0;
      disp_to_lsb     <= 1'b0;
      disp_op         <= '0;
      disp_rd         <= '0;
      disp_rs1        <= '0;
      disp_rs2        <= '0;
      disp_imm        <= '0;
      disp_pc         <= '0;
      disp_pred_taken <= 1'b0;
    end else if (!rdy) begin
      disp_valid <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      disp_valid <= 1'b0;
    end else begin
      if (store) tail <= tail + PTR_ONE;
      if (pop)   head <= head + PTR_ONE;
      if (store && !pop)      count <= count + CNT_ONE;
      else if (!store && pop) count <= count - CNT_ONE;
      disp_valid <= take;
      if (take) begin
        disp_to_rs      <= cls_to_rs(sel_dec.cls);
        disp_to_lsb     <= cls_to_lsb(sel_dec.cls);
        disp_op         <= sel_dec.op;
        disp_rd         <= sel_dec.rd;
        disp_rs1        <= sel_dec.rs1;
        disp_rs2        <= sel_dec.rs2;
        disp_imm        <= sel_dec.imm;
        disp_pc         <= sel_pc;
        disp_pred_taken <= sel_pred;
      end
    end
  end

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Directed-vector bench for inst_dispatch_queue (DEPTH=8); honours DISPATCH_BYPASS_EN.
module tb_inst_dispatch_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
`ifdef DISPATCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdy = 1'b1;
  logic            flush = 1'b0;
  logic            if_valid = 1'b0;
  logic [31:0]     if_inst = '0;
  logic [XLEN-1:0] if_pc = '0;
  logic            if_pred_taken = 1'b0;
  logic            if_ready;
  logic            rob_full = 1'b0;
  logic            rs_full = 1'b0;
  logic            lsb_full = 1'b0;
  logic            disp_valid, disp_to_rs, disp_to_lsb, disp_pred_taken;
  logic [5:0]      disp_op;
  logic [4:0]      disp_rd, disp_rs1, disp_rs2;
  logic [31:0]     disp_imm;
  logic [XLEN-1:0] disp_pc;
  logic [3:0]      count;

  int vectors = 0;
  int miscompares = 0;

  inst_dispatch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_ready(if_ready),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .disp_valid(disp_valid), .disp_to_rs(disp_to_rs), .disp_to_lsb(disp_to_lsb),
    .disp_op(disp_op), .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  // Push one word, then wait (bounded) for the dispatch pulse; n = edges taken.
  task automatic push_and_wait(input logic [31:0] inst, input logic [31:0] pc,
                               input logic pred, output int n);
    if_valid = 1'b1; if_inst = inst; if_pc = pc; if_pred_taken = pred;
    tick();
    if_valid = 1'b0;
    n = 1;
    while (!disp_valid && n < 8) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick(); tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_if_ready", if_ready, 1);
    check("rst_op", disp_op, 0);

    // addi x1, x0, 5
    push_and_wait(32'h0050_0093, 32'h0, 1'b0, n);
    check("addi_latency", n, EXP_LAT);
    check("addi_valid", disp_valid, 1);
    check("addi_op", disp_op, 19);
    check("addi_rd", disp_rd, 1);
    check("addi_rs1", disp_rs1, 0);
    check("addi_rs2", disp_rs2, 0);
    check("addi_imm", disp_imm, 5);
    check("addi_to_rs", disp_to_rs, 1);
    check("addi_to_lsb", disp_to_lsb, 0);
    tick();
    check("addi_pulse_end", disp_valid, 0);

    // sw x2, 8(x1) with the LSB full for three cycles
    lsb_full = 1'b1;
    if_valid = 1'b1; if_inst = 32'h0020_A423; if_pc = 32'h4; if_pred_taken = 1'b0;
    tick();
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sw_stall", disp_valid, 0);
      if (i < 2) tick();
    end
    lsb_full = 1'b0;
    tick();
    check("sw_valid", disp_valid, 1);
    check("sw_op", disp_op, 18);
    check("sw_to_lsb", disp_to_lsb, 1);
    check("sw_to_rs", disp_to_rs, 0);
    check("sw_rd", disp_rd, 0);
    check("sw_rs1", disp_rs1, 1);
    check("sw_rs2", disp_rs2, 2);
    check("sw_imm", disp_imm, 8);

    // beq x0, x0, -4 at 0x100, predicted taken
    push_and_wait(32'hFE00_0EE3, 32'h100, 1'b1, n);
    check("beq_latency", n, EXP_LAT);
    check("beq_op", disp_op, 5);
    check("beq_imm", disp_imm, 32'hFFFF_FFFC);
    check("beq_pc", disp_pc, 32'h100);
    check("beq_pred", disp_pred_taken, 1);
    check("beq_rd", disp_rd, 0);
    tick();

    // ROB full: nine offered, eight accepted, then drained in order across the wrap
    rob_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("fill_if_ready", if_ready, (i < 8) ? 1 : 0);
      if_valid = 1'b1;
      if_inst = addi(5'(i + 1), 12'(i));
      if_pc = 32'h200 + 32'(4 * i);
      tick();
      check("fill_no_disp", disp_valid, 0);
    end
    if_valid = 1'b0;
    check("fill_count", count, 8);
    rob_full = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("drain_valid", disp_valid, 1);
      check("drain_rd", disp_rd, j + 1);
      check("drain_pc", disp_pc, 32'h200 + 32'(4 * j));
      check("drain_imm", disp_imm, j);
    end
    tick();
    check("drain_done_valid", disp_valid, 0);
    check("drain_done_count", count, 0);

    // flush with 5 queued and a coincident push
    rob_full = 1'b1;
    if_valid = 1'b1; if_inst = addi(5'd7, 12'd7); if_pc = 32'h300;
    for (int i = 0; i < 5; i++) tick();
    check("pre_flush_count", count, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", disp_valid, 0);
    rob_full = 1'b0;
    tick();
    check("post_flush_valid", disp_valid, 0);
    check("post_flush_count", count, 0);

    // rdy low freezes everything
    rdy = 1'b0;
    if_valid = 1'b1; if_inst = addi(5'd9, 12'd9); if_pc = 32'h400;
    tick();
    check("frozen_no_push", count, 0);
    check("frozen_if_ready", if_ready, 1);
    rdy = 1'b1; rob_full = 1'b1;
    tick();
    if_valid = 1'b0;
    check("frozen_pushed", count, 1);
    rdy = 1'b0; rob_full = 1'b0;
    tick();
    check("frozen_no_pop", disp_valid, 0);
    check("frozen_count", count, 1);
    rdy = 1'b1;
    tick();
    check("thaw_valid", disp_valid, 1);
    check("thaw_rd", disp_rd, 9);
    tick();

    // unknown opcode goes to the ROB only
    push_and_wait(32'hFFFF_FFFF, 32'h500, 1'b0, n);
    check("inv_valid", disp_valid, 1);
    check("inv_op", disp_op, 0);
    check("inv_to_rs", disp_to_rs, 0);
    check("inv_to_lsb", disp_to_lsb, 0);
    tick();

    // reset mid-stream: three queued, dispatch pulse high
    rob_full = 1'b1;
    if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_inst = addi(5'(10 + i), 12'(i));
      if_pc = 32'h600 + 32'(4 * i);
      tick();
    end
    if_valid = 1'b0;
    rob_full = 1'b0;
    tick();
    check("pre_rst_valid", disp_valid, 1);
    check("pre_rst_count", count, 3);
    check("pre_rst_rd", disp_rd, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", disp_valid, 0);
    check("mid_rst_op", disp_op, 0);
    check("mid_rst_rd", disp_rd, 0);
    check("mid_rst_imm", disp_imm, 0);
    check("mid_rst_pc", disp_pc, 0);
    check("mid_rst_to_rs", disp_to_rs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_dispatch_queue.md
Name: inst_dispatch_queue

Overview:
Parametrised instruction buffer plus decode/dispatch stage for the Tomasulo RV32I core, sitting between IF and the ROB/RS/LSB.
- Buffers up to DEPTH fetched instructions, with PC and prediction bit.
- Decodes the head entry into internal op ID, rd/rs1/rs2 and sign-extended immediate.
- Dispatches at most one instruction per cycle, routed to RS or LSB, only when the ROB and the target unit have room.
- Mispredict flush empties the queue.

Parameters:
DEPTH, 8, queue entries; power of two, at least 2
PTR_W, $clog2(DEPTH), pointer width
XLEN, 32, data/PC width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; low freezes all state
flush  in  1  mispredict (jump_wrong); clears queue and output
if_valid  in  1  IF offers an instruction
if_inst  in  32  instruction word
if_pc  in  XLEN  instruction PC
if_pred_taken  in  1  IF predicted taken
if_ready  out  1  queue can accept an instruction
rob_full  in  1  ROB cannot take an entry
rs_full  in  1  RS cannot take an entry
lsb_full  in  1  LSB cannot take an entry
disp_valid  out  1  dispatch pulse, one instruction
disp_to_rs  out  1  entry goes to RS
disp_to_lsb  out  1  entry goes to LSB
disp_op  out  6  internal op ID
disp_rd  out  5  destination register
disp_rs1  out  5  source 1
disp_rs2  out  5  source 2
disp_imm  out  32  immediate
disp_pc  out  XLEN  PC
disp_pred_taken  out  1  prediction bit
count  out  PTR_W+1  occupancy

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On reset:
  - pointers and count = 0;
  - every disp_* output = 0, including disp_valid.
- if_ready = (count != DEPTH). It is combinational and does not depend on a same-cycle pop.
- Push: if_valid && if_ready && rdy && !flush writes {inst, pc, pred} at the tail; tail increments and wraps modulo DEPTH.
- Pop condition: count != 0 && rdy && !flush && !rob_full, plus !lsb_full for LOAD/STORE or !rs_full for all other classes.
  - On pop, the head is decoded and registered onto the disp_* outputs with disp_valid = 1; head increments and wraps.
  - Otherwise disp_valid = 0 on the next edge; the other disp_* outputs hold their previous value.
- Push and pop may occur in the same cycle; count is unchanged in that case.
- flush has priority over push and pop. It clears pointers and count, and drives disp_valid = 0 next edge.
- rdy = 0: no state changes, disp_valid is forced to 0, and if_ready still reflects count.
- Latency: an instruction pushed at edge N appears on disp_* after edge N+1 at the earliest.
- Full full-units stall the head in order; there is no reordering.
- Decode, op IDs:
  - 0 = invalid
  - LUI = 1, AUIPC = 2, JAL = 3, JALR = 4
  - BEQ..BGEU = 5..10
  - LB, LH, LW, LBU, LHU = 11..15
  - SB, SH, SW = 16..18
  - ADDI..SRAI = 19..27
  - ADD..AND = 28..37
- Field zeroing:
  - rd = 0 for branch and store;
  - rs1 = 0 for U/J types;
  - rs2 = 0 for U/J/I types.
- Immediates are sign-extended per I/S/B/J format. U-type imm = {inst[31:12], 12'b0}. Shift immediates = zero-extended shamt.
- Unknown opcode or funct: op 0, to_rs = to_lsb = 0, disp_valid = 1. This sends the entry to the ROB only, which keeps the instruction stream ordered.

Optional Feature:
DISPATCH_BYPASS_EN
- Defined: when count == 0 and a push occurs under an otherwise valid pop condition, the incoming instruction is decoded and registered directly onto disp_* at the same edge.
  - Queue stays empty; latency is 1 edge.
- Undefined: every instruction passes through the queue storage, with a minimum latency of 2 edges.

Decomposition:
- Shared package (define.v): op ID constants, RV32I opcode constants, instruction-class codes.
- Sub-module rv32i_decode: pure combinational decode of one 32-bit word into {op, class, rd, rs1, rs2, imm}. Used for the head entry and, when DISPATCH_BYPASS_EN is defined, also for the incoming word.

Test Plan:
- Push 0x00500093 (addi x1,x0,5), all fulls low:
  - disp_valid after 2 edges, or 1 edge with bypass;
  - op = 19, rd = 1, rs1 = 0, rs2 = 0, imm = 5, to_rs = 1.
- Push 0x0020A423 (sw x2,8(x1)) with lsb_full = 1 for 3 cycles:
  - no dispatch while lsb_full is high;
  - then op = 18, to_lsb = 1, rd = 0, rs1 = 1, rs2 = 2, imm = 8.
- Push 0xFE000EE3 (beq x0,x0,-4) at PC 0x100 with pred = 1: op = 5, imm = 0xFFFFFFFC, disp_pc = 0x100, disp_pred_taken = 1.
- Hold rob_full = 1 and push 9 instructions (DEPTH = 8):
  - if_ready drops at count = 8 and the 9th is not taken;
  - after release, 8 dispatches follow in program order, with pointers wrapping.
- Fill 5 entries, assert flush coincident with if_valid: count = 0 next edge, no disp_valid, the incoming instruction is discarded.
- Assert rst mid-stream with 3 entries queued and disp_valid high: next edge count = 0, disp_valid = 0, all disp_* = 0.
